// File: rtl/mf_capture.sv
// MF bus receiver: captures the first driven MF word of each drive window, hands it to the
// M-bus consumer, and reports ownership conflicts. Optional odd parity check: MF_CAPTURE_PARITY_EN.
module mf_capture #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             state_alu,
    input  logic             state_write,
    input  logic             state_mmu,
    input  logic             state_fetch,
    input  logic             mfdrive,
    input  logic             pdlenb,
    input  logic             spcenb,
    input  logic             srcm,
    input  logic [WIDTH-1:0] mf,
`ifdef MF_CAPTURE_PARITY_EN
    input  logic             mf_par,
    output logic             parity_err,
`endif
    input  logic             m_ack,
    input  logic             clear,
    output logic [WIDTH-1:0] m_out,
    output logic             m_valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             overrun,
    output logic             unstable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic   window;
    logic   drive;
    logic   capture;
    logic   own_clash;

    assign window    = state_alu | state_write | state_mmu | state_fetch;
    assign drive     = window & mfdrive;
    // Only the first drive of a window captures; later drives are stability checks.
    assign capture   = drive & (state != CAPT);
    assign own_clash = mfdrive & (pdlenb | spcenb | srcm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m_out    <= '0;
            m_valid  <= 1'b0;
            overrun  <= 1'b0;
            unstable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (drive)
                        state <= CAPT;
                    else if (window)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!window)
                        state <= IDLE;
                    else if (drive)
                        state <= CAPT;
                end
                CAPT: begin
                    if (!window)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                m_out   <= mf;
                m_valid <= 1'b1;
            end else if (m_valid && m_ack) begin
                m_valid <= 1'b0;
            end

            // A new set event in the same cycle as clear leaves the flag set.
            overrun  <= (overrun & ~clear) | (capture & m_valid & ~m_ack);
            unstable <= (unstable & ~clear) | ((state == CAPT) & drive & (mf != m_out));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict <= own_clash;
            if (clear)
                conflict_cnt <= own_clash ? CNT_W'(1) : '0;
            else if (own_clash && conflict_cnt != CNT_MAX)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

`ifdef MF_CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_err <= 1'b0;
        else
            parity_err <= (parity_err & ~clear) | (capture & ~(^{mf, mf_par}));
    end
`endif

endmodule

// File: doc/mf_capture.md
Name: mf_capture

Overview:
- M-side receiver for the MF bus: it samples the word on the MF lines during each MF drive window, holds it for the M-bus consumer and handshakes it out.
- Checks bus ownership for every drive: a drive that overlaps a PDL, SPC or M-memory source enable is flagged as a conflict and counted.
- Sits between the MF drivers and the M-source mux. It supplies a registered M word plus diagnostic status to the console/debug path.

Parameters:
WIDTH, 32, MF/M data width in bits
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
state_alu  in  1  machine in ALU state
state_write  in  1  machine in WRITE state
state_mmu  in  1  machine in MMU state
state_fetch  in  1  machine in FETCH state
mfdrive  in  1  an MF driver owns the bus this cycle
pdlenb  in  1  PDL driving M
spcenb  in  1  SPC driving M
srcm  in  1  M memory sourcing M (active high)
mf  in  WIDTH  MF bus data
m_ack  in  1  consumer accepts m_out
clear  in  1  synchronous clear of sticky flags and counter
m_out  out  WIDTH  captured MF word
m_valid  out  1  m_out holds an unconsumed word
conflict  out  1  one-cycle pulse on an ownership conflict
conflict_cnt  out  CNT_W  saturating conflict count
overrun  out  1  sticky: a capture replaced an unconsumed word
unstable  out  1  sticky: mf changed while still driven in the same window

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, m_out=0, FSM=IDLE.
- window = state_alu | state_write | state_mmu | state_fetch.
- drive = window & mfdrive.
- FSM states:
  - IDLE: no window open. window=1 -> ARMED, or directly -> CAPT if drive=1 in that cycle.
  - ARMED: window open, nothing captured yet. drive -> CAPT. window=0 -> IDLE.
  - CAPT: one word captured this window. window=0 -> IDLE.
- Capture:
  - The first drive cycle of a window registers mf into m_out on that clock edge.
  - m_valid=1 from the following cycle.
  - Latency is 1 clock from the drive cycle to m_out/m_valid.
- Repeated drive cycles in the same window (state CAPT) do not recapture. If mf differs from the captured m_out during such a cycle, unstable is set.
- A window that closes without any drive captures nothing and leaves m_out and m_valid unchanged.
- Handshake:
  - m_valid & m_ack consumes the word: m_valid clears next cycle and m_out holds its value.
  - m_ack while m_valid=0 is ignored.
- Overrun: a capture while m_valid=1 and m_ack=0 replaces m_out, keeps m_valid=1 and sets overrun.
- Capture and m_ack in the same cycle: capture wins. m_valid stays 1, m_out takes the new word, no overrun.
- Conflict:
  - Condition: mfdrive & (pdlenb | spcenb | srcm), evaluated every cycle regardless of window.
  - conflict pulses high the next cycle.
  - conflict_cnt increments and saturates at 2^CNT_W-1 (no wrap).
  - A conflicting drive cycle inside a window still captures.
- clear (synchronous) zeroes overrun, unstable and conflict_cnt. It does not affect m_out, m_valid or the FSM.
- clear coincident with a conflict: the counter ends at 1, and the conflict pulse still fires.
- Reset mid-window or mid-handshake discards the held word. After release, the FSM starts in IDLE even if window is still high, and the next drive in that window captures.

Optional Feature:
MF_CAPTURE_PARITY_EN.
- Defined: adds input mf_par (1 bit, odd parity over mf) and output parity_err (sticky, cleared by reset/clear).
  - On each capture, if ^{mf,mf_par} != 1, parity_err is set the following cycle.
  - Data is captured regardless of parity.
- Undefined: neither port exists and no parity logic is built.

Test Plan:
- Window of state_alu for 3 cycles with mfdrive=1 on cycle 1 and mf=32'h0000_1234 -> m_out=32'h1234 and m_valid=1 on cycle 2. The second and third drive cycles with the same mf change nothing.
- Captured word held, then m_ack=1 for one cycle -> m_valid=0 next cycle, m_out still 32'h1234.
- Capture 32'hA, no ack, then a new window captures 32'hB -> m_out=32'hB, m_valid=1, overrun=1. clear=1 for one cycle -> overrun=0.
- mfdrive=1 and pdlenb=1 for 300 consecutive cycles with CNT_W=8 -> conflict high each following cycle, conflict_cnt saturates at 255.
- Within one state_write window, drive mf=5 then mf=6 -> m_out=5, unstable=1.
- reset=0 asserted asynchronously mid-state_fetch while m_valid=1 -> all outputs 0 immediately. After release with the window still open, the next drive of mf=32'hFFFF_FFFF -> m_out=32'hFFFF_FFFF and m_valid=1 one cycle later.
